// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built from one full-adder slice and
// a carry flop. Operands are captured on an accepted start, processed LSB
// first at one bit per clock, and the result is presented with a one-cycle
// done strobe. sum/cout hold their final values until the next accepted start.
module serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state_reg;
   state_t        state_next;

   logic [N-1:0]  a_reg;
   logic [N-1:0]  b_reg;
   logic [N-1:0]  a_shift;
   logic [N-1:0]  b_shift;
   logic [N-1:0]  sum_reg;
   logic          carry_reg;
   logic          cout_reg;
   logic [CW-1:0] count_reg;

   logic          load;
   logic          last;
   logic          s_bit;
   logic          c_bit;

   // The single full-adder cell, fed from the LSBs of the operand shifters.
   assign s_bit = a_reg[0] ^ b_reg[0] ^ carry_reg;
   assign c_bit = (a_reg[0] & b_reg[0]) | ((a_reg[0] ^ b_reg[0]) & carry_reg);

   // Right-shifted operand images with zero fill at the MSB.
   genvar gi;
   generate
      for (gi = 0; gi < N - 1; gi++) begin : g_shift
         assign a_shift[gi] = a_reg[gi + 1];
         assign b_shift[gi] = b_reg[gi + 1];
      end
   endgenerate
   assign a_shift[N-1] = 1'b0;
   assign b_shift[N-1] = 1'b0;

   // State register; reset wins over everything, including an in-flight add.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic plus the load/last controls for the datapath.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      last       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // start is deliberately not looked at here: requests while busy
            // are dropped rather than queued.
            if (count_reg == LAST_BIT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            // Accepting start here lets operations run back to back.
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture on accept, one bit of addition per SHIFT edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else if (load) begin
         // sum/cout are left alone so the previous result stays visible
         // until the first shift overwrites it.
         a_reg     <= a;
         b_reg     <= b;
         carry_reg <= cin;
         count_reg <= '0;
      end else if (state_reg == SHIFT) begin
         a_reg     <= a_shift;
         b_reg     <= b_shift;
         carry_reg <= c_bit;
         sum_reg   <= {s_bit, sum_reg[N-1:1]};
         count_reg <= count_reg + 1'b1;
         if (last) begin
            cout_reg <= c_bit;
         end
      end
   end

   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scenario tasks for the bit-serial adder. Expected results
// are pushed to a scoreboard queue on each accepted start and popped when the
// DUT raises done. Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;

   int tests_run = 0;
   int tests_failed = 0;

   logic [N:0] sb[$];

   always #5 clk = ~clk;

   serial_adder #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Called at a falling edge; the start is accepted on the next rising edge.
   // Afterwards the inputs are scrambled to show they are not re-sampled.
   task automatic do_start(input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic cv, input bit track);
      logic [N:0] e;
      a = av;
      b = bv;
      cin = cv;
      start = 1'b1;
      if (track) begin
         e = {1'b0, av};
         e = e + {1'b0, bv} + {{N{1'b0}}, cv};
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      cin = 1'($urandom);
   endtask

   // Waits (bounded) for done; reports how many falling edges it took,
   // how many of those had busy high, and whether done overlapped busy.
   task automatic wait_done(output int cycles, output int busy_cnt,
                            output bit overlap, output bit ok);
      cycles = 0;
      busy_cnt = 0;
      overlap = 1'b0;
      ok = 1'b0;
      while (cycles <= 4 * N) begin
         if (done) begin
            ok = 1'b1;
            if (busy) overlap = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({busy, done, cout, sum} !== {3'b000, {N{1'b0}}}) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: busy=%b done=%b cout=%b sum=%h, want all 0",
                  busy, done, cout, sum);
      end
      $display("[TB] reset: busy=%b done=%b cout=%b sum=%h", busy, done, cout, sum);
   endtask

   task automatic test_basic();
      int cyc, bc;
      bit ov, ok;
      logic [N:0] exp_v;
      do_start(8'h5A, 8'h3C, 1'b0, 1'b1);
      wait_done(cyc, bc, ov, ok);
      exp_v = sb.pop_front();
      tests_run++;
      if (!ok || cyc != N || bc != N || ov) begin
         tests_failed++;
         $display("[TB] FAIL basic_timing: ok=%0d cycles=%0d busy=%0d overlap=%0d, want 1/%0d/%0d/0",
                  ok, cyc, bc, ov, N, N);
      end
      tests_run++;
      if ({cout, sum} !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL basic_result: got %h, want %h", {cout, sum}, exp_v);
      end
      $display("[TB] basic: a=5a b=3c cin=0 -> cout=%b sum=%h", cout, sum);
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || {cout, sum} !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL basic_hold: done=%b result=%h, want done=0 result=%h",
                  done, {cout, sum}, exp_v);
      end
   endtask

   task automatic test_carry();
      logic [N-1:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
      logic [N-1:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
      logic         tc[3] = '{1'b0, 1'b1, 1'b1};
      logic [N:0]   tr[3] = '{9'h100, 9'h1FF, 9'h001};
      int cyc, bc;
      bit ov, ok;
      logic [N:0] exp_v;
      for (int i = 0; i < 3; i++) begin
         do_start(ta[i], tb[i], tc[i], 1'b1);
         wait_done(cyc, bc, ov, ok);
         exp_v = sb.pop_front();
         tests_run++;
         if (!ok || {cout, sum} !== exp_v || {cout, sum} !== tr[i]) begin
            tests_failed++;
            $display("[TB] FAIL carry_%0d: ok=%0d got %h, want %h", i, ok, {cout, sum}, tr[i]);
         end
         $display("[TB] carry: a=%h b=%h cin=%b -> cout=%b sum=%h", ta[i], tb[i], tc[i], cout, sum);
         @(negedge clk);
      end
   endtask

   task automatic test_start_busy();
      int cyc, bc;
      bit ov, ok;
      logic [N:0] exp_v;
      do_start(8'h10, 8'h20, 1'b0, 1'b1);
      fork
         wait_done(cyc, bc, ov, ok);
         begin
            repeat (2) @(negedge clk);
            a = 8'hFF;
            b = 8'hFF;
            cin = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      exp_v = sb.pop_front();
      tests_run++;
      if (!ok || cyc != N || bc != N) begin
         tests_failed++;
         $display("[TB] FAIL busy_start_timing: ok=%0d cycles=%0d busy=%0d, want 1/%0d/%0d",
                  ok, cyc, bc, N, N);
      end
      tests_run++;
      if ({cout, sum} !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL busy_start_result: got %h, want %h", {cout, sum}, exp_v);
      end
      $display("[TB] start-while-busy: a=10 b=20 -> cout=%b sum=%h", cout, sum);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc, bc;
      bit ov, ok, seen;
      logic [N:0] exp_v;
      do_start(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({busy, done, cout, sum} !== {3'b000, {N{1'b0}}}) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_state: busy=%b done=%b cout=%b sum=%h, want all 0",
                  busy, done, cout, sum);
      end
      seen = 1'b0;
      for (int i = 0; i < 2 * N; i++) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      tests_run++;
      if (seen) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_no_done: done strobe seen=1, want 0");
      end
      do_start(8'h12, 8'h34, 1'b1, 1'b1);
      wait_done(cyc, bc, ov, ok);
      exp_v = sb.pop_front();
      tests_run++;
      if (!ok || cyc != N || {cout, sum} !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_restart: ok=%0d cycles=%0d got %h, want %h",
                  ok, cyc, {cout, sum}, exp_v);
      end
      $display("[TB] reset-mid then a=12 b=34 cin=1 -> cout=%b sum=%h", cout, sum);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc, bc;
      bit ov, ok;
      logic [N:0] exp_v;
      do_start(8'h80, 8'h80, 1'b0, 1'b1);
      wait_done(cyc, bc, ov, ok);
      exp_v = sb.pop_front();
      tests_run++;
      if (!ok || {cout, sum} !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first: ok=%0d got %h, want %h", ok, {cout, sum}, exp_v);
      end
      $display("[TB] b2b first: a=80 b=80 -> cout=%b sum=%h", cout, sum);
      do_start(8'h01, 8'h02, 1'b1, 1'b1);
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
      end
      wait_done(cyc, bc, ov, ok);
      exp_v = sb.pop_front();
      tests_run++;
      if (!ok || cyc != N || bc != N || {cout, sum} !== exp_v || {cout, sum} !== 9'h004) begin
         tests_failed++;
         $display("[TB] FAIL b2b_second: ok=%0d cycles=%0d got %h, want %h",
                  ok, cyc, {cout, sum}, exp_v);
      end
      $display("[TB] b2b second: a=01 b=02 cin=1 -> cout=%b sum=%h", cout, sum);
      @(negedge clk);
   endtask

   task automatic test_random();
      int cyc, bc, gap;
      bit ov, ok;
      logic [N:0] exp_v;
      logic [N-1:0] ra, rb;
      logic rc;
      for (int i = 0; i < 200; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rc = 1'($urandom);
         do_start(ra, rb, rc, 1'b1);
         wait_done(cyc, bc, ov, ok);
         exp_v = (sb.size() > 0) ? sb.pop_front() : 'x;
         tests_run++;
         if (!ok || cyc != N || bc != N || ov || {cout, sum} !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL random_%0d: a=%h b=%h cin=%b ok=%0d cycles=%0d busy=%0d overlap=%0d got %h want %h",
                     i, ra, rb, rc, ok, cyc, bc, ov, {cout, sum}, exp_v);
         end
         $display("[TB] random %0d: a=%h b=%h cin=%b -> cout=%b sum=%h", i, ra, rb, rc, cout, sum);
         @(negedge clk);
         tests_run++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL random_strobe_%0d: done=%b busy=%b, want 0/0", i, done, busy);
         end
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single one-bit full adder slice (sum = a^b^cin, carry = majority(a,b,cin)) and a carry flip-flop.
- Accepts two N-bit operands plus carry-in on a start pulse. Processes one bit per clock, LSB first. Presents the N-bit sum and carry-out with a one-cycle done strobe.
- Sits directly downstream of the combinational full-adder stage: it is the sequential wrapper the lab datapath uses to add multi-bit words with one adder cell.

Parameters:
- N, 8, operand/sum width in bits (N >= 2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled on rising edge of clk
- a  input  N  operand A; captured on accepted start only
- b  input  N  operand B; captured on accepted start only
- cin  input  1  carry-in; captured on accepted start only
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle strobe; sum/cout valid
- sum  output  N  result; registered
- cout  output  1  final carry-out; registered

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: rst sampled high on a rising clk edge forces state=IDLE.
  - Reset clears busy=0, done=0, sum=0, cout=0, the operand shift registers, the carry flop and the bit counter.
  - rst has priority over start and over any in-flight operation. Reset mid-SHIFT aborts with no done strobe.
- FSM states IDLE, SHIFT, DONE; encoding is free.
- IDLE:
  - start=1 loads A<=a, B<=b, carry<=cin, count<=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, per edge:
  - s_bit = A[0]^B[0]^carry.
  - carry <= (A[0]&B[0]) | ((A[0]^B[0])&carry).
  - The sum register shifts right with s_bit entering at MSB.
  - A and B shift right (zero fill).
  - count <= count+1.
  - On the edge where count==N-1 (the Nth bit is processed): cout <= new carry, move to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (load, go to SHIFT), which allows back-to-back operations.
  - Otherwise go to IDLE.
- busy:
  - busy=1 exactly while state==SHIFT: N consecutive cycles per operation.
  - start while busy=1 is ignored; operands, carry and count are unaffected.
- Latency:
  - start accepted at edge k → done high in the cycle after edge k+N.
  - That is, N+1 edges from accept to done visible.
- Output validity:
  - sum is intermediate (partially shifted) while busy=1.
  - From edge k+N onward, sum and cout hold the final result until the next accepted start.
  - sum and cout are not cleared on entry to IDLE.
- Arithmetic: {cout,sum} == a + b + cin, exact modulo 2^(N+1). No overflow flag; cout is the unsigned carry.
- Counter width is clog2(N). No wrap issues, because the counter is reloaded to 0 on every accept.
- Inputs a/b/cin changing after acceptance have no effect on the result.

Test Plan:
- Basic add: rst 2 cycles, then start with a=0x5A, b=0x3C, cin=0 (N=8) → busy high 8 cycles, done 1 cycle at start-edge+9, sum=0x96, cout=0.
- Carry chain / all combos:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Start while busy: accept a=0x10, b=0x20, cin=0; pulse start with a=0xFF, b=0xFF at cycle 3 of SHIFT → ignored; done on schedule with sum=0x30, cout=0.
- Reset mid-operation: accept a=0xAA, b=0x55; assert rst at SHIFT cycle 4 → next edge busy=0, done=0, sum=0x00, cout=0; no done strobe follows. A fresh start then completes normally.
- Back-to-back: hold start=1 in the DONE cycle with a=0x01, b=0x02, cin=1 → first result stays visible that cycle, second op begins, second done 9 edges later with sum=0x04, cout=0.
- Randomized: 200 random a/b/cin with random idle gaps → {cout,sum} == a+b+cin at every done. done is never high with busy, and each done is exactly one cycle.
